matrix_seq_gen: RTL

//  Parametrised test-sequence generator feeding matrix operands to the SoC bench driver.
//  On start it produces NUM_OPS operand matrices (A, B, ...) per test, for NUM_TESTS tests.

---
 rtl/matrix_seq_gen.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/matrix_seq_gen.sv
// ---------------------------------------------------------------------------
// matrix_seq_gen
//   Test-sequence generator that feeds matrix operands to a bench driver.
//   A start request launches a run of num_tests tests, each made of NUM_OPS
//   operand matrices. Each matrix is built one element per cycle into an
//   internal buffer, then offered on a valid/ack handshake.
//
//   Handshake: sequence_valid_o stays high, and sequence_o and the indices
//   stay stable, until a cycle with sequence_send_i=1. That edge completes the
//   transfer. sequence_send_i is ignored while sequence_valid_o is low. The
//   ack may arrive in the same cycle that valid rises.
//
// Ports
//   clk_i, rst_ni       clock, synchronous active-low reset
//   test_start_i        start request, sampled only in IDLE
//   abort_i             abandon the run and return to IDLE (no done pulse)
//   mode_i, const_i     fill mode and CONST value, latched at start
//   num_tests_i         tests per run (0 counts as 1), latched at start
//   sequence_o          packed row-major matrix, element i at [i*DATA_W +: DATA_W]
//   sequence_valid_o    matrix offered; sequence_send_i is the consumer ack
//   op_idx_o/test_idx_o indices of the matrix currently built or offered
//   busy_o, done_o      not-idle flag; one-cycle run-complete pulse
// ---------------------------------------------------------------------------
module matrix_seq_gen #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAT_DIM   = 4,
  parameter int unsigned NUM_OPS   = 2,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024,
  parameter int unsigned LO_MAX    = 50,
  parameter int unsigned HI_MIN    = 100,
  parameter int unsigned HI_MAX    = 150
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                test_start_i,
  input  logic                                abort_i,
  input  logic [1:0]                          mode_i,
  input  logic [DATA_W-1:0]                   const_i,
  input  logic [15:0]                         num_tests_i,
  output logic [MAT_DIM*MAT_DIM*DATA_W-1:0]   sequence_o,
  output logic                                sequence_valid_o,
  input  logic                                sequence_send_i,
  output logic [2:0]                          op_idx_o,
  output logic [15:0]                         test_idx_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int unsigned ELEMS = MAT_DIM * MAT_DIM;
  localparam int unsigned SEQ_W = ELEMS * DATA_W;
  localparam int unsigned CTR_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [CTR_W-1:0] LAST_ELEM = CTR_W'(ELEMS - 1);
  localparam logic [2:0]       LAST_OP   = 3'(NUM_OPS - 1);
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0]      LFSR_POLY = 32'h8020_0003;
  localparam logic [15:0]      LO_MOD    = 16'(LO_MAX + 1);
  localparam logic [15:0]      HI_MOD    = 16'(HI_MAX - HI_MIN + 1);
  localparam logic [15:0]      HI_BASE   = 16'(HI_MIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                valid_q, valid_d;
  logic [2:0]          op_q, op_d;
  logic [15:0]         test_q, test_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   const_q, const_d;
  logic [15:0]         last_test_q, last_test_d;

  logic [31:0]         lfsr_step;
  logic [15:0]         rnd_val;
  logic [31:0]         incr_val;
  logic [DATA_W-1:0]   elem_val;

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    seq_d       = seq_q;
    valid_d     = valid_q;
    op_d        = op_q;
    test_d      = test_q;
    done_d      = 1'b0;
    lfsr_d      = lfsr_q;
    mode_d      = mode_q;
    const_d     = const_q;
    last_test_d = last_test_q;

    // Value of the element being written this cycle. In RANDOM mode the
    // element uses the freshly stepped LFSR state.
    lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
    if ((lfsr_step[31:16] % 16'd6) == 16'd0) begin
      rnd_val = lfsr_step[15:0] % LO_MOD;
    end else begin
      rnd_val = HI_BASE + (lfsr_step[15:0] % HI_MOD);
    end
    incr_val = 32'(op_q) * 32'(ELEMS) + 32'(ctr_q);
    case (mode_q)
      2'd0:    elem_val = DATA_W'(rnd_val);
      2'd1:    elem_val = DATA_W'(incr_val);
      2'd2:    elem_val = const_q;
      default: elem_val = ((32'(ctr_q) % 32'(MAT_DIM + 1)) == 32'd0) ? DATA_W'(1) : '0;
    endcase

    case (state_q)
      S_IDLE: begin
        // Start beats abort here; abort has no meaning while idle.
        if (test_start_i) begin
          mode_d      = mode_i;
          const_d     = const_i;
          last_test_d = (num_tests_i == 16'd0) ? 16'd0 : num_tests_i - 16'd1;
          op_d        = '0;
          test_d      = '0;
          ctr_d       = '0;
          state_d     = S_GEN;
        end
      end
      S_GEN: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          seq_d[32'(ctr_q) * DATA_W +: DATA_W] = elem_val;
          if (mode_q == 2'd0) lfsr_d = lfsr_step;
          ctr_d = ctr_q + 1'b1;
          if (ctr_q == LAST_ELEM) begin
            ctr_d   = '0;
            valid_d = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (sequence_send_i) begin
          valid_d = 1'b0;
          if (op_q < LAST_OP) begin
            op_d    = op_q + 3'd1;
            state_d = S_GEN;
          end else if (test_q < last_test_q) begin
            op_d    = '0;
            test_d  = test_q + 16'd1;
            state_d = S_GEN;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        // S_DONE: done_q is high for this single cycle; abort changes nothing.
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ctr_q       <= '0;
      seq_q       <= '0;
      valid_q     <= 1'b0;
      op_q        <= '0;
      test_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      mode_q      <= '0;
      const_q     <= '0;
      last_test_q <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      seq_q       <= seq_d;
      valid_q     <= valid_d;
      op_q        <= op_d;
      test_q      <= test_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lfsr_q      <= lfsr_d;
      mode_q      <= mode_d;
      const_q     <= const_d;
      last_test_q <= last_test_d;
    end
  end

  assign sequence_o       = seq_q;
  assign sequence_valid_o = valid_q;
  assign op_idx_o         = op_q;
  assign test_idx_o       = test_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule
